// File: rtl/timer_pkg.sv
// Shared types and default widths for the prescaled down-count timer.
package timer_pkg;

  localparam int CNT_W_D = 16;
  localparam int PSC_W_D = 5;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_START  = 2'd1,
    OP_STOP   = 2'd2,
    OP_UPDATE = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/timer_core.sv
// Prescaler plus down counter; load has priority over counting.
module timer_core
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_D,
  parameter int PSC_W = PSC_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic [CNT_W-1:0] reload,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             zero
);

  logic [PSC_W-1:0] pcnt;

  assign tick = en && (pcnt == psc);
  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (load) begin
      pcnt <= '0;
      cnt  <= reload;
    end else if (en) begin
      if (tick) begin
        pcnt <= '0;
        // The counter floors at zero: reaching it re-arms from reload instead of wrapping.
        cnt  <= zero ? reload : cnt - 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Command sequencer for the timer core: FSM, shadow registers, expiry and sticky flags.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_D,
  parameter int PSC_W = PSC_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [PSC_W-1:0] cmd_psc,
  input  logic [CNT_W-1:0] cmd_reload,
  input  logic             cmd_periodic,
  input  logic             irq_clr,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic             expire,
  output logic             irq,
  output logic             overrun
);

  state_e           state, state_nxt;
  cmd_op_e          op;
  logic             acc, start_acc, stop_acc, upd_acc;
  logic [PSC_W-1:0] psc_q;
  logic [CNT_W-1:0] reload_q;
  logic             periodic_q;
  logic             core_load, core_en, tick, zero;
  logic [CNT_W-1:0] core_reload;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state != LOAD);
  assign busy      = (state != IDLE);
  assign acc       = cmd_valid && cmd_ready;
  assign start_acc = acc && (op == OP_START);
  assign stop_acc  = acc && (op == OP_STOP);
  assign upd_acc   = acc && (op == OP_UPDATE);

  assign core_load = (state == LOAD);
  assign core_en   = (state == RUN);
  assign expire    = (state == RUN) && tick && zero;

  // A coincident UPDATE feeds the periodic re-arm directly; one-shot re-arms to 0 so cnt holds 0.
  always_comb begin
    core_reload = reload_q;
    if (state == RUN) begin
      if (!periodic_q)  core_reload = '0;
      else if (upd_acc) core_reload = cmd_reload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_acc) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
        if (start_acc)                  state_nxt = LOAD;
        else if (stop_acc)              state_nxt = IDLE;
        else if (expire && !periodic_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q      <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
    end else if (start_acc) begin
      psc_q      <= cmd_psc;
      reload_q   <= cmd_reload;
      periodic_q <= cmd_periodic;
    end else if (upd_acc) begin
      reload_q   <= cmd_reload;
    end
  end

  // Setting by an expiry always wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (expire)       irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      if (expire && irq) overrun <= 1'b1;
      else if (irq_clr)  overrun <= 1'b0;
    end
  end

  timer_core #(
    .CNT_W (CNT_W),
    .PSC_W (PSC_W)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .en     (core_en),
    .psc    (psc_q),
    .reload (core_reload),
    .cnt    (cnt),
    .tick   (tick),
    .zero   (zero)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: period-arithmetic reference model plus directed cycle checks.
module tb_timer_ctrl;

  localparam int CNT_W = 16;
  localparam int PSC_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [PSC_W-1:0] cmd_psc = '0;
  logic [CNT_W-1:0] cmd_reload = '0;
  logic             cmd_periodic = 1'b0;
  logic             irq_clr = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic             expire;
  logic             irq;
  logic             overrun;

  timer_ctrl #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_psc      (cmd_psc),
    .cmd_reload   (cmd_reload),
    .cmd_periodic (cmd_periodic),
    .irq_clr      (irq_clr),
    .busy         (busy),
    .cnt          (cnt),
    .expire       (expire),
    .irq          (irq),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: a period is described by its start cycle and reload; cnt and expiry follow by division.
  bit m_load, m_run, m_per, m_irq, m_ovr;
  int m_psc, m_rel, m_cur, m_t0, m_hold;

  logic             s_ready, s_busy, s_exp, s_irq, s_ovr;
  logic [CNT_W-1:0] s_cnt;

  task automatic model_reset();
    m_load = 0; m_run = 0; m_per = 0; m_irq = 0; m_ovr = 0;
    m_psc = 0; m_rel = 0; m_cur = 0; m_t0 = 0; m_hold = 0;
  endtask

  task automatic cycle(input bit v, input logic [1:0] op, input int psc, input int rel,
                       input bit per, input bit clr, input bit rst);
    int e, e_cnt, nxt;
    bit e_exp, acc;
    logic [CNT_W-1:0]   ec;
    logic [CNT_W+4:0]   got, want;
    reset = rst; cmd_valid = v; cmd_op = op; cmd_periodic = per; irq_clr = clr;
    cmd_psc = psc[PSC_W-1:0]; cmd_reload = rel[CNT_W-1:0];
    #1;
    s_ready = cmd_ready; s_busy = busy; s_exp = expire; s_irq = irq; s_ovr = overrun; s_cnt = cnt;
    e = 0; e_exp = 0; e_cnt = m_hold;
    if (m_run) begin
      e     = cyc - m_t0;
      e_cnt = m_cur - e / (m_psc + 1);
      e_exp = (e == (m_cur + 1) * (m_psc + 1) - 1);
    end
    ec   = e_cnt[CNT_W-1:0];
    got  = {s_ready, s_busy, s_exp, s_irq, s_ovr, s_cnt};
    want = {!m_load, m_load || m_run, e_exp, m_irq, m_ovr, ec};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL model cyc=%0d got rdy/busy/exp/irq/ovr/cnt=%b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
               cyc, s_ready, s_busy, s_exp, s_irq, s_ovr, s_cnt,
               !m_load, m_load || m_run, e_exp, m_irq, m_ovr, e_cnt);
    end
    acc = v && !m_load;
    nxt = m_hold;
    if (m_run) begin
      if (e_exp) nxt = m_per ? ((acc && op == 2'd3) ? rel : m_rel) : 0;
      else       nxt = m_cur - (e + 1) / (m_psc + 1);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (e_exp && m_irq) m_ovr = 1;
      else if (clr)       m_ovr = 0;
      if (e_exp)    m_irq = 1;
      else if (clr) m_irq = 0;
      if (m_load) begin
        m_load = 0; m_run = 1; m_t0 = cyc + 1; m_cur = m_rel;
      end else begin
        if (m_run) begin
          m_hold = nxt;
          if (e_exp) begin
            if (m_per) begin m_t0 = cyc + 1; m_cur = nxt; end
            else m_run = 0;
          end
        end
        if (acc) begin
          case (op)
            2'd1: begin m_psc = psc; m_rel = rel; m_per = per; m_run = 0; m_load = 1; end
            2'd2: m_run = 0;
            2'd3: m_rel = rel;
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(0, 2'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(0, 2'd0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    idle_cycle();
    tests++;
    if ({s_busy, s_irq, s_ovr, s_exp, s_ready} !== 5'b00001 || s_cnt !== '0) begin
      fails++;
      $display("FAIL reset_state got busy/irq/ovr/exp/rdy=%b%b%b%b%b cnt=%0d required 00001 cnt=0",
               s_busy, s_irq, s_ovr, s_exp, s_ready, s_cnt);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    for (int i = 0; i < 26; i++) begin
      if (i == 0) cycle(1, 2'd1, 3, 4, 0, 0, 0);
      else        idle_cycle();
      tests++;
      if (s_exp !== (i == 21)) begin
        fails++; $display("FAIL oneshot_expire cyc%0d got %b required %b", i, s_exp, i == 21);
      end
      if (i >= 22) begin
        tests++;
        if ({s_irq, s_busy} !== 2'b10 || s_cnt !== '0) begin
          fails++; $display("FAIL oneshot_done cyc%0d got irq/busy=%b%b cnt=%0d required 10 cnt=0",
                            i, s_irq, s_busy, s_cnt);
        end
      end
    end
  endtask

  task automatic test_periodic_overrun();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(i == 0, 2'd1, 0, 2, 1, i == 12, 0);
      tests++;
      if (s_exp !== (i == 4 || i == 7 || i == 10 || i == 13)) begin
        fails++; $display("FAIL periodic_expire cyc%0d got %b", i, s_exp);
      end
      if (i >= 8 && i <= 12) begin
        tests++;
        if (s_ovr !== 1'b1) begin fails++; $display("FAIL overrun_set cyc%0d got %b required 1", i, s_ovr); end
      end
      if (i == 13) begin
        tests++;
        if ({s_irq, s_ovr} !== 2'b00) begin
          fails++; $display("FAIL irq_clr cyc13 got irq/ovr=%b%b required 00", s_irq, s_ovr);
        end
      end
    end
    cycle(1, 2'd2, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stop();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i == 0)       cycle(1, 2'd1, 3, 4, 0, 0, 0);
      else if (i == 10) cycle(1, 2'd2, 0, 0, 0, 0, 0);
      else              idle_cycle();
      tests++;
      if (s_exp !== 1'b0) begin fails++; $display("FAIL stop_noexpire cyc%0d got %b required 0", i, s_exp); end
      if (i >= 11) begin
        tests++;
        if (s_busy !== 1'b0 || s_cnt !== 16'd2) begin
          fails++; $display("FAIL stop_freeze cyc%0d got busy=%b cnt=%0d required busy=0 cnt=2", i, s_busy, s_cnt);
        end
      end
    end
  endtask

  task automatic test_update();
    do_reset();
    for (int i = 0; i < 23; i++) begin
      if (i == 0)      cycle(1, 2'd1, 0, 2, 1, 0, 0);
      else if (i == 7) cycle(1, 2'd3, 0, 5, 0, 0, 0);
      else             idle_cycle();
      tests++;
      if (s_exp !== (i == 4 || i == 7 || i == 13 || i == 19)) begin
        fails++; $display("FAIL update_expire cyc%0d got %b", i, s_exp);
      end
    end
    cycle(1, 2'd2, 0, 0, 0, 0, 0);
  endtask

  task automatic test_restart();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (i == 0)      cycle(1, 2'd1, 1, 6, 0, 0, 0);
      else if (i == 5) cycle(1, 2'd1, 0, 3, 0, 0, 0);
      else             idle_cycle();
      tests++;
      if (s_exp !== (i == 10)) begin fails++; $display("FAIL restart_expire cyc%0d got %b", i, s_exp); end
      if (i == 6) begin
        tests++;
        if (s_ready !== 1'b0) begin fails++; $display("FAIL restart_ready cyc6 got %b required 0", s_ready); end
      end
      if (i == 7) begin
        tests++;
        if (s_cnt !== 16'd3) begin fails++; $display("FAIL restart_cnt cyc7 got %0d required 3", s_cnt); end
      end
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(i == 0, 2'd1, 0, 2, 1, i == 4, i == 6);
      if (i == 5) begin
        tests++;
        if (s_irq !== 1'b1) begin fails++; $display("FAIL clr_vs_expire cyc5 got irq=%b required 1", s_irq); end
      end
      if (i == 7) begin
        tests++;
        if ({s_busy, s_irq, s_ready} !== 3'b001 || s_cnt !== '0) begin
          fails++; $display("FAIL reset_midrun got busy/irq/rdy=%b%b%b cnt=%0d required 001 cnt=0",
                            s_busy, s_irq, s_ready, s_cnt);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(7) == 0, 2'($urandom_range(3)), $urandom_range(3), $urandom_range(9),
            1'($urandom_range(1)), $urandom_range(15) == 0, $urandom_range(199) == 0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic_overrun();
    test_stop();
    test_update();
    test_restart();
    test_clear_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the prescaled down-count timer. It accepts START/STOP/UPDATE commands over a valid/ready handshake and loads the prescaler and reload values into an internal timer core. It runs one-shot or auto-reload periods and reports each expiry as a pulse, plus a sticky interrupt and an overrun flag. It sits between the bus-side register logic and the timer datapath, and is the only agent that drives the core's load and enable.

## Interface
Parameters:
- `CNT_W`, default 16: down-counter and reload width.
- `PSC_W`, default 5: prescaler width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  operation: 0 NOP, 1 START, 2 STOP, 3 UPDATE.
- `cmd_psc`  in  `PSC_W`  prescale value; used by START only.
- `cmd_reload`  in  `CNT_W`  reload value; used by START and UPDATE.
- `cmd_periodic`  in  1  mode; 1 = auto-reload, 0 = one-shot; used by START only.
- `irq_clr`  in  1  clears `irq` and `overrun`.
- `busy`  out  1  state is not IDLE.
- `cnt`  out  `CNT_W`  current down-counter value.
- `expire`  out  1  one-cycle expiry pulse.
- `irq`  out  1  sticky expiry flag.
- `overrun`  out  1  sticky flag: an expiry occurred while `irq` was already set.

## Operation
- **States:** IDLE, LOAD, RUN.
- **Reset:** state IDLE; `cnt`, prescaler count, `psc`/`reload`/mode registers, `irq`, `overrun` and `expire` are all 0.
- **`cmd_ready`:** equals 1 in IDLE and RUN, 0 in LOAD.
- **IDLE + START:**
  - Latch `cmd_psc`, `cmd_reload`, `cmd_periodic`.
  - Go to LOAD.
  - STOP and NOP are accepted with no effect.
  - UPDATE writes the reload register only.
- **LOAD (exactly 1 cycle):**
  - Core load asserted: `cnt` becomes reload, prescaler count becomes 0.
  - Go to RUN.
- **RUN, prescaler:**
  - The prescaler count increments each cycle.
  - `tick` = (count == psc); on `tick` the count wraps to 0.
  - Tick period is psc+1 cycles.
- **RUN, on `tick`:**
  - If `cnt` != 0: decrement `cnt`.
  - If `cnt` == 0: expiry. `expire` = 1 this cycle.
  - Periodic mode: `cnt` <= reload; stay in RUN.
  - One-shot mode: go to IDLE; `cnt` holds 0.
- **RUN + START:** restart. Latch the new values and go to LOAD; an expiry in the same cycle is still reported.
- **RUN + STOP:** go to IDLE next cycle; `cnt` holds its value.
- **RUN + UPDATE:** the reload register is written; it takes effect at the next expiry. If UPDATE and a periodic expiry occur in the same cycle, the new value is the one loaded.
- **`irq`:**
  - Set by `expire` (registered).
  - Cleared by `irq_clr`; set wins if both occur in the same cycle.
- **`overrun`:**
  - Set when `expire` occurs while `irq` = 1.
  - Cleared by `irq_clr`; set wins if both occur in the same cycle.
- **Arithmetic:** unsigned throughout; `cnt` never wraps below 0.
- **Boundary values:**
  - psc = 0: tick every RUN cycle.
  - reload = 0: expiry on the first tick.

## Timing
- Cycle 0 is the cycle in which START is accepted. Cycle 1 is LOAD; cycle 2 is the first RUN cycle, with `cnt` = reload.
- Let N = (reload+1)·(psc+1). `expire` is high in cycle N+1.
- `irq` is high from cycle N+2.
- One-shot: `busy` is low from cycle N+2.
- Periodic: subsequent `expire` pulses every N cycles.
- STOP accepted in cycle k: `busy` = 0 in cycle k+1. No `expire` after cycle k, except a coincident expiry in cycle k itself, which is reported.
- `reset` asserted in any state: all outputs at reset values in the next cycle, and any in-flight command is dropped.

## Structure
- **Package `timer_pkg`:**
  - `cmd_op_e` enum (NOP/START/STOP/UPDATE).
  - `state_e` enum (IDLE/LOAD/RUN).
  - Default width constants `CNT_W_D` = 16 and `PSC_W_D` = 5.
- **Sub-module `timer_core`:**
  - Inputs: `clk`, `reset`, `load`, `en`, `psc`, `reload`.
  - Outputs: `cnt`, `tick`, `zero`.
  - Contains the prescaler and down counter.
  - `timer_ctrl` holds the FSM, command decode, shadow registers and flag logic.

## Test plan
- **One-shot:** START psc=3, reload=4, periodic=0 in cycle 0 → `expire` only in cycle 21; `irq`=1 and `busy`=0 from cycle 22; `cnt`=0 thereafter.
- **Periodic + overrun:** START psc=0, reload=2, periodic=1 → `expire` in cycles 4, 7, 10. `overrun`=1 from cycle 8 (no `irq_clr`). `irq_clr` in cycle 12 → both flags 0 in cycle 13.
- **Stop:** STOP in cycle 10 of a psc=3, reload=4 run → `busy`=0 in cycle 11; `cnt` frozen at 2; no `expire`.
- **UPDATE coincident with expiry:** periodic run psc=0, reload=2; UPDATE reload=5 in cycle 7 (coincides with `expire`) → next `expire` in cycle 13, the one after in cycle 19.
- **Restart and handshake:** START in cycle 5 during RUN → `cmd_ready`=0 in cycle 6; `cnt` = new reload in cycle 7; the old period never expires.
- **Reset and clear priority:** `reset` mid-RUN → next cycle IDLE, `cnt`=0, `irq`=0, `cmd_ready`=1. `irq_clr` coincident with `expire` → `irq` set.
